// File: rtl/csa_resolve_adder.sv
// csa_resolve_adder: pipelined, segmented carry-propagate adder that collapses
// a carry-save pair (in_c, in_s) into one binary sum, resolving SEG_LEN bits
// per stage. A global stall (advance) gives the consumer backpressure control.
module csa_resolve_adder #(
  parameter int BIT_LEN = 21,
  parameter int SEG_LEN = 8,
  parameter int NUM_SEG = (BIT_LEN + SEG_LEN - 1) / SEG_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIT_LEN-1:0] in_c,
  input  logic [BIT_LEN-1:0] in_s,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BIT_LEN:0]   out_sum
);

  // The top slice adder is built at its true width instead of zero-extending
  // it to SEG_LEN: its carry-out then lands exactly on bit BIT_LEN, which is
  // the same value the zero-extended slice would produce there.
  localparam int TOP_W = BIT_LEN - (NUM_SEG - 1) * SEG_LEN;

  logic advance;

  // Stage k holds valid, resolved sum bits [HI-1:0], the carry out of slice k
  // and the still-unresolved c/s bits [BIT_LEN-1:HI].
  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    localparam int LO = k * SEG_LEN;
    localparam int SW = (k == NUM_SEG - 1) ? TOP_W : SEG_LEN;
    localparam int HI = LO + SW;

    logic          v_q, v_d, v_in;
    logic          cy_q, cy_d, cin;
    logic [SW-1:0] op_c, op_s;
    logic [SW:0]   add;
    logic [HI-1:0] sum_in, sum_q, sum_d;

    if (k == 0) begin : g_src
      assign v_in   = in_valid;
      assign op_c   = in_c[SW-1:0];
      assign op_s   = in_s[SW-1:0];
      assign cin    = 1'b0;
      assign sum_in = add[SW-1:0];
    end else begin : g_src
      assign v_in   = g_stage[k-1].v_q;
      assign op_c   = g_stage[k-1].g_rem.c_q[SW-1:0];
      assign op_s   = g_stage[k-1].g_rem.s_q[SW-1:0];
      assign cin    = g_stage[k-1].cy_q;
      assign sum_in = {add[SW-1:0], g_stage[k-1].sum_q};
    end

    // Slice adder: operand slice k plus the carry from the previous slice.
    always_comb begin
      add = {1'b0, op_c} + {1'b0, op_s} + {{SW{1'b0}}, cin};
    end

    // Next state: load from the predecessor on advance, otherwise hold.
    always_comb begin
      v_d   = v_q;
      cy_d  = cy_q;
      sum_d = sum_q;
      if (advance) begin
        v_d   = v_in;
        cy_d  = add[SW];
        sum_d = sum_in;
      end
    end

    // Stage registers; reset clears valid and data alike.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q   <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else begin
        v_q   <= v_d;
        cy_q  <= cy_d;
        sum_q <= sum_d;
      end
    end

    // Unresolved operand bits travel alongside until their slice is reached.
    if (k < NUM_SEG - 1) begin : g_rem
      localparam int RW = BIT_LEN - HI;

      logic [RW-1:0] c_in, s_in, c_q, c_d, s_q, s_d;

      if (k == 0) begin : g_in
        assign c_in = in_c[BIT_LEN-1:HI];
        assign s_in = in_s[BIT_LEN-1:HI];
      end else begin : g_in
        assign c_in = g_stage[k-1].g_rem.c_q[BIT_LEN-LO-1:SW];
        assign s_in = g_stage[k-1].g_rem.s_q[BIT_LEN-LO-1:SW];
      end

      // Next operand state: shift forward on advance, otherwise hold.
      always_comb begin
        c_d = c_q;
        s_d = s_q;
        if (advance) begin
          c_d = c_in;
          s_d = s_in;
        end
      end

      // Operand registers.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          c_q <= '0;
          s_q <= '0;
        end else begin
          c_q <= c_d;
          s_q <= s_d;
        end
      end
    end
  end

  assign out_valid = g_stage[NUM_SEG-1].v_q;
  assign out_sum   = {g_stage[NUM_SEG-1].cy_q, g_stage[NUM_SEG-1].sum_q};

  // Global stall: the whole pipeline moves only when the output slot frees up.
  always_comb begin
    advance  = !out_valid || out_ready;
    in_ready = advance;
  end

endmodule

// File: tb/tb_csa_resolve_adder.sv
// Testbench for csa_resolve_adder: directed vectors with hand-computed sums
// and random soaks, checked by queue-based scoreboards that pop on each
// output handshake.
module tb_csa_resolve_adder;
  localparam int BL = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- main DUT (default segmentation) ----------------
  logic          reset, in_valid, in_ready, out_valid, out_ready;
  logic [BL-1:0] in_c, in_s;
  logic [BL:0]   out_sum, exp_next;
  logic [BL:0]   exp_q[$];
  int            n_in = 0;
  int            n_out = 0;

  csa_resolve_adder #(.BIT_LEN(BL), .SEG_LEN(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_c(in_c), .in_s(in_s), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum)
  );

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (reset) begin
      n_in = n_in - exp_q.size();
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_next);
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL main_unexpected_out: got 0x%0h, required no output", out_sum);
        end else begin
          chk("main_sum", out_sum, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BL-1:0] c, input logic [BL-1:0] s, input logic [BL:0] e);
    in_valid = 1'b1;
    in_c     = c;
    in_s     = s;
    exp_next = e;
  endtask

  // ---------------- soak DUTs for other segmentations ----------------
  for (genvar g = 0; g < 3; g++) begin : g_soak
    localparam int SEG = (g == 0) ? 1 : ((g == 1) ? 5 : 21);

    logic          rst, iv, ir, ov, ordy, done;
    logic [BL-1:0] c, s;
    logic [BL:0]   sum, en;
    logic [BL:0]   q[$];
    int            ni = 0;
    int            no = 0;

    csa_resolve_adder #(.BIT_LEN(BL), .SEG_LEN(SEG)) dut (
      .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir),
      .in_c(c), .in_s(s), .out_valid(ov), .out_ready(ordy), .out_sum(sum)
    );

    // Per-instance scoreboard.
    always @(negedge clk) begin
      if (!rst) begin
        if (iv && ir) begin
          q.push_back(en);
          ni++;
        end
        if (ov && ordy) begin
          no++;
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL soak%0d_unexpected_out: got 0x%0h, required no output", SEG, sum);
          end else begin
            chk($sformatf("soak%0d_sum", SEG), sum, q.pop_front());
          end
        end
      end
    end

    initial begin
      done = 1'b0;
      rst  = 1'b1;
      iv   = 1'b0;
      ordy = 1'b1;
      c    = '0;
      s    = '0;
      en   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 10000; i++) begin
        iv   = 1'($urandom_range(0, 1));
        ordy = ($urandom_range(0, 3) != 0);
        c    = BL'($urandom());
        s    = BL'($urandom());
        en   = {1'b0, c} + {1'b0, s};
        @(posedge clk);
        #1;
      end
      iv   = 1'b0;
      ordy = 1'b1;
      repeat (30) @(posedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("soak%0d_count_io", SEG), 64'(ni), 64'(no));
      chk($sformatf("soak%0d_queue_empty", SEG), 64'(q.size()), 0);
      done = 1'b1;
    end
  end

  // ---------------- main directed sequence ----------------
  initial begin
    int base;
    logic [BL-1:0] rc, rs;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_c      = '0;
    in_s      = '0;
    exp_next  = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Single add: valid appears after the third edge counting the accept edge.
    send(21'h00000F, 21'h000001, 22'h000010);
    step();
    in_valid = 1'b0;
    chk("lat_edge1_valid", out_valid, 0);
    step();
    chk("lat_edge2_valid", out_valid, 0);
    step();
    chk("lat_edge3_valid", out_valid, 1);
    chk("lat_edge3_sum", out_sum, 22'h000010);
    step();
    chk("lat_drop_valid", out_valid, 0);

    // Full carry ripple across every slice.
    send(21'h1FFFFF, 21'h000001, 22'h200000);
    step();
    send(21'h1FFFFF, 21'h1FFFFF, 22'h3FFFFE);
    step();
    in_valid = 1'b0;
    repeat (4) step();

    // Back-to-back stream of 20: all must emerge in 20 consecutive cycles.
    base = n_out;
    for (int i = 0; i < 20; i++) begin
      rc = BL'($urandom());
      rs = BL'($urandom());
      send(rc, rs, {1'b0, rc} + {1'b0, rs});
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    #1;
    chk("stream_count", 64'(n_out - base), 20);
    step();
    chk("stream_end_valid", out_valid, 0);

    // Backpressure: fill the pipe with the output stalled.
    out_ready = 1'b0;
    send(21'h000100, 21'h000200, 22'h000300);
    step();
    send(21'h0ABCDE, 21'h054321, 22'h0FFFFF);
    step();
    send(21'h100000, 21'h100000, 22'h200000);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_sum", out_sum, 22'h000300);
      step();
    end
    out_ready = 1'b1;
    send(21'h000FFF, 21'h000001, 22'h001000);
    #1;
    chk("bp_take_and_accept", in_ready, 1);
    step();
    in_valid = 1'b0;
    repeat (5) step();

    // Reset while two results are in flight: nothing may emerge afterwards.
    send(21'h012345, 21'h000001, 22'h012346);
    step();
    send(21'h0AAAAA, 21'h055555, 22'h0FFFFF);
    step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_quiet", out_valid, 0);
    end

    // Random soak with random valid/ready.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rc        = BL'($urandom());
      rs        = BL'($urandom());
      in_c      = rc;
      in_s      = rs;
      exp_next  = {1'b0, rc} + {1'b0, rs};
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    #1;
    chk("main_count_io", 64'(n_in), 64'(n_out));
    chk("main_queue_empty", 64'(exp_q.size()), 0);

    for (int i = 0; i < 20000; i++) begin
      if (g_soak[0].done && g_soak[1].done && g_soak[2].done) break;
      step();
    end
    chk("soak_done", {g_soak[2].done, g_soak[1].done, g_soak[0].done}, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
